// File: rtl/error_countdown_timer_pkg.sv
// Shared constants for the error countdown timer: error codes, timer state encodings, second limits.
// Optional feature macro used by the timer: ERR_TIMER_PAUSE_EN.
package error_countdown_timer_pkg;

    localparam logic [3:0] ERR_NONE    = 4'd0;
    localparam logic [3:0] ERR_DIM     = 4'd1;
    localparam logic [3:0] ERR_RANGE   = 4'd2;
    localparam logic [3:0] ERR_OP      = 4'd3;
    localparam logic [3:0] ERR_TIMEOUT = 4'd4;

    localparam logic [1:0] TMR_IDLE   = 2'd0;
    localparam logic [1:0] TMR_LOAD   = 2'd1;
    localparam logic [1:0] TMR_COUNT  = 2'd2;
    localparam logic [1:0] TMR_EXPIRE = 2'd3;

    localparam logic [3:0]  MAX_SECS     = 4'd9;
    localparam int unsigned DEFAULT_SECS = 5;

    // Zero selects the default; anything above the single-digit display range is clamped.
    function automatic logic [3:0] clamp_secs(input logic [3:0] cfg, input logic [3:0] dflt);
        logic [3:0] secs;
        secs = (cfg == 4'd0) ? dflt : cfg;
        return (secs > MAX_SECS) ? MAX_SECS : secs;
    endfunction

endpackage

// File: rtl/error_countdown_timer_tick_prescaler.sv
// One-second strobe generator: counts enabled cycles and pulses tick on the last one of each period.
module tick_prescaler #(
    parameter int unsigned TICK_CYCLES = 100_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        tick  = en && !clr && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/error_countdown_timer.sv
// Error latch and seconds countdown feeding the display controller; strobes timeout_pulse on expiry.
// Optional pause input enabled by defining ERR_TIMER_PAUSE_EN.
module error_countdown_timer #(
    parameter int unsigned TICK_CYCLES  = 100_000_000,
    parameter int unsigned DEFAULT_SECS = error_countdown_timer_pkg::DEFAULT_SECS
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       err_req,
    input  logic [3:0] err_code_in,
    input  logic [3:0] cfg_secs,
    input  logic       retry,
`ifdef ERR_TIMER_PAUSE_EN
    input  logic       pause,
`endif
    output logic [3:0] error_code,
    output logic [3:0] countdown_val,
    output logic       timeout_pulse,
    output logic       busy
);

    import error_countdown_timer_pkg::*;

    logic [1:0] state_q;
    logic [1:0] state_d;
    logic [3:0] error_code_q;
    logic [3:0] error_code_d;
    logic [3:0] countdown_q;
    logic [3:0] countdown_d;
    logic       timeout_pulse_q;
    logic       timeout_pulse_d;
    logic       busy_q;
    logic       busy_d;

    logic       new_err;
    logic [3:0] new_secs;
    logic       hold;
    logic       tick;
    logic       presc_clr;
    logic       presc_en;

    assign new_err  = err_req && (err_code_in != ERR_NONE);
    assign new_secs = clamp_secs(cfg_secs, 4'(DEFAULT_SECS));

`ifdef ERR_TIMER_PAUSE_EN
    assign hold = pause;
`else
    assign hold = 1'b0;
`endif

    // Clearing on a reload or retry keeps the prescaler at zero in every cycle spent outside COUNT.
    assign presc_clr = (state_q != TMR_COUNT) || new_err || retry;
    assign presc_en  = (state_q == TMR_COUNT) && !hold;

    tick_prescaler #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (presc_clr),
        .en   (presc_en),
        .tick (tick)
    );

    always_comb begin
        state_d      = state_q;
        error_code_d = error_code_q;
        countdown_d  = countdown_q;

        case (state_q)
            TMR_IDLE: begin
                if (new_err) begin
                    state_d = TMR_LOAD;
                end
            end
            TMR_LOAD: begin
                if (new_err) begin
                    state_d = TMR_LOAD;
                end else if (retry) begin
                    state_d = TMR_IDLE;
                end else begin
                    state_d = TMR_COUNT;
                end
            end
            TMR_COUNT: begin
                if (new_err) begin
                    state_d = TMR_LOAD;
                end else if (retry) begin
                    state_d = TMR_IDLE;
                end else if (tick) begin
                    if (countdown_q != 4'd0) begin
                        countdown_d = countdown_q - 1'b1;
                    end else begin
                        state_d = TMR_EXPIRE;
                    end
                end
            end
            default: begin
                state_d = new_err ? TMR_LOAD : TMR_IDLE;
            end
        endcase

        // Outputs are registered from the next state so the code and count appear on the err_req edge.
        if (new_err) begin
            error_code_d = err_code_in;
            countdown_d  = new_secs;
        end
        if (state_d == TMR_IDLE) begin
            error_code_d = ERR_NONE;
            countdown_d  = 4'd0;
        end

        busy_d          = (state_d != TMR_IDLE);
        timeout_pulse_d = (state_d == TMR_EXPIRE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= TMR_IDLE;
            error_code_q    <= ERR_NONE;
            countdown_q     <= 4'd0;
            timeout_pulse_q <= 1'b0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            error_code_q    <= error_code_d;
            countdown_q     <= countdown_d;
            timeout_pulse_q <= timeout_pulse_d;
            busy_q          <= busy_d;
        end
    end

    assign error_code    = error_code_q;
    assign countdown_val = countdown_q;
    assign timeout_pulse = timeout_pulse_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_error_countdown_timer.sv
// Scoreboard bench for error_countdown_timer: stimulus queues expected output changes, a monitor checks them.
module tb_error_countdown_timer;

    localparam int unsigned T = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       err_req = 1'b0;
    logic [3:0] err_code_in = 4'd0;
    logic [3:0] cfg_secs = 4'd0;
    logic       retry = 1'b0;
`ifdef ERR_TIMER_PAUSE_EN
    logic       pause = 1'b0;
`endif
    logic [3:0] error_code;
    logic [3:0] countdown_val;
    logic       timeout_pulse;
    logic       busy;

    error_countdown_timer #(
        .TICK_CYCLES (T),
        .DEFAULT_SECS(5)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .err_req      (err_req),
        .err_code_in  (err_code_in),
        .cfg_secs     (cfg_secs),
        .retry        (retry),
`ifdef ERR_TIMER_PAUSE_EN
        .pause        (pause),
`endif
        .error_code   (error_code),
        .countdown_val(countdown_val),
        .timeout_pulse(timeout_pulse),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  code;
        logic [3:0]  val;
        logic        pulse;
        logic        busy;
        int unsigned at;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         failures = 0;
    logic       mon_en = 1'b0;
    logic [9:0] prev = '0;

    task automatic push(input logic [3:0] c, input logic [3:0] v, input logic p, input logic b,
                        input int unsigned at);
        exp_t e;
        e.code = c; e.val = v; e.pulse = p; e.busy = b; e.at = at;
        sb.push_back(e);
    endtask

    // Expected change list for an uninterrupted run that enters LOAD at edge base.
    task automatic push_run(input logic [3:0] c, input int unsigned n, input int unsigned base);
        push(c, 4'(n), 1'b0, 1'b1, base);
        for (int unsigned k = 1; k <= n; k++) push(c, 4'(n - k), 1'b0, 1'b1, base + 1 + T * k);
        push(c, 4'd0, 1'b1, 1'b1, base + 1 + T * (n + 1));
        push(4'd0, 4'd0, 1'b0, 1'b0, base + 2 + T * (n + 1));
    endtask

    always @(negedge clk) begin
        logic [9:0] cur;
        exp_t e;
        cur = {error_code, countdown_val, timeout_pulse, busy};
        if (mon_en && cur != prev) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_change cyc=%0d got code=%0d val=%0d pulse=%0b busy=%0b",
                         cyc, cur[9:6], cur[5:2], cur[1], cur[0]);
            end else begin
                e = sb.pop_front();
                if (cur != {e.code, e.val, e.pulse, e.busy} || cyc != e.at) begin
                    failures++;
                    $display("FAIL output_event got code=%0d val=%0d pulse=%0b busy=%0b at cyc=%0d, expected code=%0d val=%0d pulse=%0b busy=%0b at cyc=%0d",
                             cur[9:6], cur[5:2], cur[1], cur[0], cyc, e.code, e.val, e.pulse, e.busy, e.at);
                end
            end
            prev = cur;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int unsigned c);
        while (cyc < c) step();
    endtask

    task automatic raise(input logic [3:0] code, input logic [3:0] cfg, input logic with_retry);
        err_code_in = code;
        cfg_secs    = cfg;
        err_req     = 1'b1;
        retry       = with_retry;
        step();
        err_req     = 1'b0;
        retry       = 1'b0;
        err_code_in = 4'd0;
    endtask

    task automatic pulse_retry();
        retry = 1'b1;
        step();
        retry = 1'b0;
    endtask

    task automatic check_now(input string name, input logic [9:0] want);
        logic [9:0] got;
        got = {error_code, countdown_val, timeout_pulse, busy};
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, want);
        end
    endtask

    initial begin
        int unsigned s;

        repeat (3) step();
        check_now("reset_state", 10'h000);
        rst_n = 1'b1;
        mon_en = 1'b1;
        step();

        // basic run, cfg 2
        s = cyc; raise(4'd3, 4'd2, 1'b0); push_run(4'd3, 2, s + 1);
        wait_until(s + 40);

        // cfg 0 selects default 5
        s = cyc; raise(4'd1, 4'd0, 1'b0); push_run(4'd1, 5, s + 1);
        wait_until(s + 70);

        // cfg 12 clamps to 9, then retry in first second
        s = cyc; raise(4'd1, 4'd12, 1'b0); push(4'd1, 4'd9, 1'b0, 1'b1, s + 1);
        wait_until(s + 4); push(4'd0, 4'd0, 1'b0, 1'b0, s + 5); pulse_retry();
        wait_until(s + 10);

        // retry mid-second at countdown 1
        s = cyc; raise(4'd4, 4'd2, 1'b0);
        push(4'd4, 4'd2, 1'b0, 1'b1, s + 1);
        push(4'd4, 4'd1, 1'b0, 1'b1, s + 12);
        wait_until(s + 16); push(4'd0, 4'd0, 1'b0, 1'b0, s + 17); pulse_retry();
        wait_until(s + 60);

        // latest error wins, prescaler restarts
        s = cyc; raise(4'd2, 4'd4, 1'b0); push(4'd2, 4'd4, 1'b0, 1'b1, s + 1);
        wait_until(s + 5); raise(4'd5, 4'd3, 1'b0); push_run(4'd5, 3, s + 6);
        wait_until(s + 55);

        // err_req and retry together: reload wins
        s = cyc; raise(4'd1, 4'd1, 1'b0); push(4'd1, 4'd1, 1'b0, 1'b1, s + 1);
        wait_until(s + 5); raise(4'd6, 4'd2, 1'b1); push_run(4'd6, 2, s + 6);
        wait_until(s + 45);

        // code 0 request and retry in IDLE are ignored
        raise(4'd0, 4'd3, 1'b0);
        pulse_retry();
        step();
        check_now("idle_ignores", 10'h000);

        // new error during EXPIRE still lets the pulse fire
        s = cyc; raise(4'd2, 4'd1, 1'b0);
        push(4'd2, 4'd1, 1'b0, 1'b1, s + 1);
        push(4'd2, 4'd0, 1'b0, 1'b1, s + 12);
        push(4'd2, 4'd0, 1'b1, 1'b1, s + 22);
        wait_until(s + 22); raise(4'd7, 4'd1, 1'b0); push_run(4'd7, 1, s + 23);
        wait_until(s + 50);

        // cfg change during COUNT has no effect
        s = cyc; raise(4'd4, 4'd1, 1'b0); push_run(4'd4, 1, s + 1);
        wait_until(s + 3); cfg_secs = 4'd7;
        wait_until(s + 30);

        // asynchronous reset mid-count
        s = cyc; raise(4'd3, 4'd3, 1'b0); push(4'd3, 4'd3, 1'b0, 1'b1, s + 1);
        wait_until(s + 8);
        #1; push(4'd0, 4'd0, 1'b0, 1'b0, s + 8); rst_n = 1'b0;
        #1; check_now("async_reset", 10'h000);
        #1; rst_n = 1'b1;
        wait_until(s + 50);

`ifdef ERR_TIMER_PAUSE_EN
        // pause for 25 cycles delays expiry by 25
        s = cyc; raise(4'd3, 4'd1, 1'b0);
        push(4'd3, 4'd1, 1'b0, 1'b1, s + 1);
        push(4'd3, 4'd0, 1'b0, 1'b1, s + 12 + 25);
        push(4'd3, 4'd0, 1'b1, 1'b1, s + 22 + 25);
        push(4'd0, 4'd0, 1'b0, 1'b0, s + 23 + 25);
        wait_until(s + 3); pause = 1'b1;
        wait_until(s + 28); pause = 1'b0;
        wait_until(s + 60);
`endif

        wait_until(cyc + 5);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL missing_event expected code=%0d val=%0d pulse=%0b busy=%0b at cyc=%0d, not observed",
                     e.code, e.val, e.pulse, e.busy, e.at);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
